seq_chunk_adder: RTL and testbench

//  Parametrised multi-cycle add/subtract unit; successor to the fixed 10-bit ripple adder.

---
 rtl/seq_chunk_adder.sv | 130 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract unit, CHUNK bits per clock with a registered inter-chunk carry.
// Optional feature: define SEQ_ADDER_SAT_EN for signed saturation of the result on overflow.
module seq_chunk_adder #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH-1:0]       acc;
    logic                   carry;
    logic [CNT_W-1:0]       cnt;

    logic                   accept;
    logic [CHUNK:0]         csum;
    logic                   cout;
    logic                   cin_msb;
    logic [WIDTH+CHUNK-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_next;
    logic [WIDTH-1:0]       final_sum;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // One chunk of the ripple per clock; the carry into the chunk MSB is recovered from the sum bit.
    assign csum     = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    assign cout     = csum[CHUNK];
    assign cin_msb  = opa[CHUNK-1] ^ opb[CHUNK-1] ^ csum[CHUNK-1];
    assign acc_cat  = {csum[CHUNK-1:0], acc};
    assign acc_next = acc_cat[WIDTH+CHUNK-1:CHUNK];

`ifdef SEQ_ADDER_SAT_EN
    logic a_msb;

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                  input logic overflow, input logic neg);
        if (!overflow)
            return wrapped;
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    always_ff @(posedge clk) begin
        if (accept)
            a_msb <= A[WIDTH-1];
    end

    assign final_sum = saturate(acc_next, cin_msb ^ cout, a_msb);
`else
    assign final_sum = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum       <= final_sum;
                        co        <= cout;
                        ovf       <= cin_msb ^ cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Operand shift registers and accumulator carry no reset; they are fully reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa <= A;
            opb <= B ^ {WIDTH{sub}};
        end else if (state == RUN) begin
            opa <= opa >> CHUNK;
            opb <= opb >> CHUNK;
            acc <= acc_next;
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed vector table, stall/reset sequences and random ops vs an arithmetic model.
module tb_seq_chunk_adder;
    localparam int W  = 10;
    localparam int C  = 2;
    localparam int N  = W / C;
    localparam int W2 = 16;
    localparam int C2 = 4;
    localparam int N2 = W2 / C2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_ready, sub, out_valid, out_ready, co, ovf;
    logic [W-1:0]  A, B, sum;
    logic          iv16, ir16, sub16, ov16, or16, co16, ovf16;
    logic [W2-1:0] A16, B16, sum16;

    int errors = 0;
    int checks = 0;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf)
    );

    seq_chunk_adder #(.WIDTH(W2), .CHUNK(C2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .A(A16), .B(B16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .co(co16), .ovf(ovf16)
    );

`ifdef SEQ_ADDER_SAT_EN
    localparam logic [W-1:0] T3_SUM  = 10'h1FF;
    localparam logic [W-1:0] T3B_SUM = 10'h200;
`else
    localparam logic [W-1:0] T3_SUM  = 10'h200;
    localparam logic [W-1:0] T3B_SUM = 10'h1FF;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] esum;
        logic         eco;
        logic         eovf;
    } vec_t;

    vec_t tab[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: unsigned modular sum for sum/co, signed range test for ovf.
    function automatic void model(input int w, input longint a, input longint b, input logic s,
                                  output longint sm, output logic c, output logic o);
        longint m, tot, sa, sb, r;
        m   = longint'(1) << w;
        tot = s ? (a + (m - 1 - b) + 1) : (a + b);
        c   = (tot >= m);
        sm  = tot % m;
        sa  = (a >= m / 2) ? a - m : a;
        sb  = (b >= m / 2) ? b - m : b;
        r   = s ? sa - sb : sa + sb;
        o   = (r < -(m / 2)) || (r >= m / 2);
`ifdef SEQ_ADDER_SAT_EN
        if (o)
            sm = (sa < 0) ? m / 2 : m / 2 - 1;
`endif
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input int stall, input string nm);
        int lat;
        @(negedge clk);
        A = a; B = b; sub = s; in_valid = 1'b1; out_ready = (stall == 0);
        chk({nm, " in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, N);
        chk({nm, " sum"}, sum, es);
        chk({nm, " co"}, co, ec);
        chk({nm, " ovf"}, ovf, eo);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = W'($urandom); B = W'($urandom);
            @(posedge clk); #1;
            chk({nm, " stall out_valid"}, out_valid, 1);
            chk({nm, " stall sum"}, sum, es);
            chk({nm, " stall co/ovf"}, {co, ovf}, {ec, eo});
            chk({nm, " stall in_ready"}, in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, " out_valid drop"}, out_valid, 0);
        chk({nm, " in_ready after"}, in_ready, 1);
        chk({nm, " sum held"}, sum, es);
    endtask

    task automatic do_op16(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic s,
                           input logic [W2-1:0] es, input logic ec, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        A16 = a; B16 = b; sub16 = s; iv16 = 1'b1;
        chk({nm, " in_ready"}, ir16, 1);
        @(posedge clk); #1;
        iv16 = 1'b0; A16 = W2'($urandom); B16 = W2'($urandom);
        lat = 0;
        while (!ov16 && lat < 4 * N2) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, N2);
        chk({nm, " sum"}, sum16, es);
        chk({nm, " co/ovf"}, {co16, ovf16}, {ec, eo});
        @(posedge clk); #1;
        chk({nm, " out_valid drop"}, ov16, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]  ra, rb;
        logic [W2-1:0] ra16, rb16;
        logic          rs, ec, eo, seen;
        longint        es;

        tab[0] = '{10'd300, 10'd200, 1'b0, 10'd500, 1'b0, 1'b0};
        tab[1] = '{10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0};
        tab[2] = '{10'h1FF, 10'h001, 1'b0, T3_SUM,  1'b0, 1'b1};
        tab[3] = '{10'h200, 10'h001, 1'b1, T3B_SUM, 1'b1, 1'b1};
        tab[4] = '{10'd5,   10'd7,   1'b1, 10'h3FE, 1'b0, 1'b0};
        tab[5] = '{10'h000, 10'h000, 1'b1, 10'h000, 1'b1, 1'b0};
        tab[6] = '{10'h155, 10'h0AA, 1'b0, 10'h1FF, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; out_ready = 1'b1;
        iv16 = 1'b0; A16 = '0; B16 = '0; sub16 = 1'b0; or16 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset co/ovf", {co, ovf}, 0);
        chk("reset in_ready low", in_ready, 0);
        chk("reset out_valid16", ov16, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++)
            do_op(tab[i].a, tab[i].b, tab[i].s, tab[i].esum, tab[i].eco, tab[i].eovf, 0,
                  $sformatf("vec%0d", i));

        do_op(10'd300, 10'd200, 1'b0, 10'd500, 1'b0, 1'b0, 3, "T5 stall");

        // Reset asserted during the second RUN cycle aborts the operation.
        @(negedge clk);
        A = 10'd300; B = 10'd200; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("T6 out_valid", out_valid, 0);
        chk("T6 sum", sum, 0);
        chk("T6 co/ovf", {co, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("T6 in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (2 * N) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("T6 no result", seen, 0);
        do_op(10'd300, 10'd200, 1'b0, 10'd500, 1'b0, 1'b0, 0, "T6 retry");

        do_op16(16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0, "T4 w16");

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            model(W, longint'(ra), longint'(rb), rs, es, ec, eo);
            do_op(ra, rb, rs, W'(es), ec, eo, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            ra16 = W2'($urandom); rb16 = W2'($urandom); rs = 1'($urandom);
            model(W2, longint'(ra16), longint'(rb16), rs, es, ec, eo);
            do_op16(ra16, rb16, rs, W2'(es), ec, eo, $sformatf("rand16_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
